seq_detector_param: RTL and testbench

Parametrised two-input synchronous sequence detector, the generalised successor of the lab's fixed two-flip-flop sequential circuit. On each enabled clock edge it samples the 2-bit symbol {A,B} and compares the last LEN symbols against a compile-time pattern. It reports matches as a Mealy pulse and as a registered pulse, and keeps a saturating match count. Selectable overlapping or non-overlapping detection adds behaviour the fixed circuit does not have.

---
 rtl/seq_detector_param.sv | 77 +++++++
 tb/tb_seq_detector_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised two-input sequence detector: matches the last LEN {A,B} symbols
// against PATTERN, with Mealy and registered match pulses and a saturating count.
module seq_detector_param #(
   parameter int               LEN     = 4,
   parameter logic [2*LEN-1:0] PATTERN = 8'b00_01_10_11,
   parameter int               CNT_W   = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    EN,
   input  logic                    CLR,
   input  logic                    OVL,
   input  logic                    A,
   input  logic                    B,
   output logic                    MATCH_M,
   output logic                    MATCH_R,
   output logic [CNT_W-1:0]        COUNT,
   output logic                    SAT,
   output logic [$clog2(LEN)-1:0]  PROG
);

   localparam int              HW        = 2 * (LEN - 1);
   localparam int              PW        = $clog2(LEN);
   localparam logic [PW-1:0]   PROG_FULL = PW'(LEN - 1);

   logic [HW-1:0]    hist_q, hist_d;
   logic [PW-1:0]    prog_q, prog_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             match_r_q, match_r_d;
   logic [2*LEN-1:0] window;
   logic             hit;

   always_comb begin
      window    = {hist_q, A, B};
      hit       = EN && !CLR && (prog_q == PROG_FULL) && (window == PATTERN);
      hist_d    = hist_q;
      prog_d    = prog_q;
      count_d   = count_q;
      match_r_d = 1'b0;
      if (CLR) begin
         hist_d  = '0;
         prog_d  = '0;
         count_d = '0;
      end else if (EN) begin
         // The newest LEN-1 symbols of the window become the history.
         hist_d    = window[HW-1:0];
         match_r_d = hit;
         if (hit) begin
            prog_d = OVL ? PROG_FULL : '0;
            if (count_q != '1) count_d = count_q + 1'b1;
         end else if (prog_q != PROG_FULL) begin
            prog_d = prog_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hist_q    <= '0;
         prog_q    <= '0;
         count_q   <= '0;
         match_r_q <= 1'b0;
      end else begin
         hist_q    <= hist_d;
         prog_q    <= prog_d;
         count_q   <= count_d;
         match_r_q <= match_r_d;
      end
   end

   assign MATCH_M = hit;
   assign MATCH_R = match_r_q;
   assign COUNT   = count_q;
   assign SAT     = &count_q;
   assign PROG    = prog_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three LEN=3 instances on one input stream,
// checked every cycle against a symbol-window model plus directed expectations.
module tb_seq_detector_param;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic EN = 1'b0, CLR = 1'b0, OVL = 1'b0, A = 1'b0, B = 1'b0;

   logic       mm [3];
   logic       mr [3];
   logic       sat[3];
   logic [1:0] pg [3];
   logic [7:0] c0, c1;
   logic [1:0] c2;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: symbols accepted since the last restart (at most LEN-1 = 2 kept).
   int pat [3][3] = '{'{1, 3, 2}, '{1, 1, 1}, '{1, 1, 1}};
   int cap [3]    = '{255, 255, 3};
   int win [3][2];
   int wn  [3];
   int cnt [3];
   int mrx [3];

   always #5 CLK = ~CLK;

   seq_detector_param #(.LEN(3), .PATTERN(6'b01_11_10), .CNT_W(8)) u0 (
      .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .OVL(OVL), .A(A), .B(B),
      .MATCH_M(mm[0]), .MATCH_R(mr[0]), .COUNT(c0), .SAT(sat[0]), .PROG(pg[0]));
   seq_detector_param #(.LEN(3), .PATTERN(6'b01_01_01), .CNT_W(8)) u1 (
      .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .OVL(OVL), .A(A), .B(B),
      .MATCH_M(mm[1]), .MATCH_R(mr[1]), .COUNT(c1), .SAT(sat[1]), .PROG(pg[1]));
   seq_detector_param #(.LEN(3), .PATTERN(6'b01_01_01), .CNT_W(2)) u2 (
      .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .OVL(OVL), .A(A), .B(B),
      .MATCH_M(mm[2]), .MATCH_R(mr[2]), .COUNT(c2), .SAT(sat[2]), .PROG(pg[2]));

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int dut_cnt(input int k);
      if (k == 0) return int'(c0);
      if (k == 1) return int'(c1);
      return int'(c2);
   endfunction

   function automatic int model_hit(input int k, input int sym);
      return (EN && !CLR && wn[k] == 2 && win[k][0] == pat[k][0] &&
              win[k][1] == pat[k][1] && sym == pat[k][2]) ? 1 : 0;
   endfunction

   // Compare at mid-cycle, then advance the model by the symbol the next edge consumes.
   always @(negedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < 3; k++) begin
            wn[k] = 0; cnt[k] = 0; mrx[k] = 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            int sym, h;
            sym = {A, B};
            h   = model_hit(k, sym);
            chk($sformatf("model k%0d MATCH_M", k), int'(mm[k]), h);
            chk($sformatf("model k%0d MATCH_R", k), int'(mr[k]), mrx[k]);
            chk($sformatf("model k%0d COUNT", k), dut_cnt(k), cnt[k]);
            chk($sformatf("model k%0d SAT", k), int'(sat[k]), (cnt[k] == cap[k]) ? 1 : 0);
            chk($sformatf("model k%0d PROG", k), int'(pg[k]), wn[k]);
            if (CLR) begin
               wn[k] = 0; cnt[k] = 0; mrx[k] = 0;
            end else if (EN) begin
               mrx[k] = h;
               if (h && cnt[k] < cap[k]) cnt[k]++;
               if (h && !OVL) wn[k] = 0;
               else if (wn[k] < 2) begin win[k][wn[k]] = sym; wn[k]++; end
               else begin win[k][0] = win[k][1]; win[k][1] = sym; end
            end else begin
               mrx[k] = 0;
            end
         end
      end
   end

   // Apply one cycle of inputs shortly after the edge; returns before mid-cycle.
   task automatic cyc(input logic en, input logic clr, input logic ovl, input logic [1:0] ab);
      @(posedge CLK);
      #1;
      EN = en; CLR = clr; OVL = ovl; {A, B} = ab;
      #2;
   endtask

   initial begin
      @(posedge CLK);
      #1;
      chk("reset MATCH_M", int'(mm[0]), 0);
      chk("reset MATCH_R", int'(mr[0]), 0);
      chk("reset COUNT", int'(c0), 0);
      chk("reset SAT", int'(sat[0]), 0);
      chk("reset PROG", int'(pg[0]), 0);
      #1 RST = 1'b0;

      // Basic match 01 11 10 on u0
      cyc(1, 0, 1, 2'b01); chk("basic PROG before 1st", int'(pg[0]), 0);
      cyc(1, 0, 1, 2'b11); chk("basic MATCH_M on 2nd", int'(mm[0]), 0);
      cyc(1, 0, 1, 2'b10); chk("basic MATCH_M on 3rd", int'(mm[0]), 1);
      chk("basic PROG before 3rd", int'(pg[0]), 2);
      cyc(0, 0, 1, 2'b00); chk("basic MATCH_R", int'(mr[0]), 1);
      chk("basic COUNT", int'(c0), 1);
      chk("basic PROG after", int'(pg[0]), 2);
      cyc(0, 0, 1, 2'b00); chk("basic MATCH_R one cycle", int'(mr[0]), 0);

      // Six 01 symbols, overlapping
      cyc(0, 1, 1, 2'b00);
      for (int i = 1; i <= 6; i++) begin
         cyc(1, 0, 1, 2'b01);
         chk($sformatf("ovl1 MATCH_M s%0d", i), int'(mm[1]), (i >= 3) ? 1 : 0);
      end
      cyc(0, 0, 1, 2'b00);
      chk("ovl1 COUNT", int'(c1), 4);
      chk("ovl1 CNT_W=2 COUNT", int'(c2), 3);

      // Six 01 symbols, non-overlapping
      cyc(0, 1, 0, 2'b00);
      for (int i = 1; i <= 6; i++) begin
         cyc(1, 0, 0, 2'b01);
         chk($sformatf("ovl0 MATCH_M s%0d", i), int'(mm[1]), (i == 3 || i == 6) ? 1 : 0);
         if (i == 4) chk("ovl0 PROG after match", int'(pg[1]), 0);
      end
      cyc(0, 0, 0, 2'b00);
      chk("ovl0 COUNT", int'(c1), 2);
      chk("ovl0 PROG after 2nd match", int'(pg[1]), 0);

      // Saturation on the CNT_W=2 instance, 8 symbols
      cyc(0, 1, 1, 2'b00);
      for (int i = 1; i <= 9; i++) begin
         int m;
         if (i <= 8) cyc(1, 0, 1, 2'b01);
         else cyc(0, 0, 1, 2'b00);
         m = (i - 3 > 0) ? i - 3 : 0;
         if (m > 3) m = 3;
         chk($sformatf("sat COUNT c%0d", i), int'(c2), m);
         chk($sformatf("sat SAT c%0d", i), int'(sat[2]), (m == 3) ? 1 : 0);
         chk($sformatf("sat MATCH_R c%0d", i), int'(mr[2]), (i >= 4) ? 1 : 0);
      end

      // EN gating on u0
      cyc(0, 1, 1, 2'b00);
      cyc(1, 0, 1, 2'b01);
      cyc(1, 0, 1, 2'b11);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 2'b10);
         chk($sformatf("en MATCH_M idle%0d", i), int'(mm[0]), 0);
         chk($sformatf("en PROG idle%0d", i), int'(pg[0]), 2);
      end
      cyc(1, 0, 1, 2'b10); chk("en MATCH_M enabled", int'(mm[0]), 1);
      cyc(0, 0, 1, 2'b00); chk("en COUNT", int'(c0), 1);

      // Asynchronous reset mid-stream on u0
      cyc(1, 0, 1, 2'b01);
      cyc(1, 0, 1, 2'b11);
      @(posedge CLK);
      #1;
      EN = 1'b1; CLR = 1'b0; {A, B} = 2'b10; RST = 1'b1;
      #1;
      chk("rst MATCH_M", int'(mm[0]), 0);
      chk("rst MATCH_R", int'(mr[0]), 0);
      chk("rst COUNT", int'(c0), 0);
      chk("rst SAT", int'(sat[0]), 0);
      chk("rst PROG", int'(pg[0]), 0);
      RST = 1'b0;
      #1;
      chk("rst no match on 10", int'(mm[0]), 0);
      cyc(0, 0, 1, 2'b00);
      chk("rst PROG after edge", int'(pg[0]), 1);
      chk("rst COUNT after edge", int'(c0), 0);

      // CLR on a completing symbol on u0
      cyc(0, 1, 1, 2'b00);
      cyc(1, 0, 1, 2'b01);
      cyc(1, 0, 1, 2'b11);
      cyc(1, 0, 1, 2'b10);
      cyc(1, 0, 1, 2'b01);
      cyc(1, 0, 1, 2'b11);
      chk("clr COUNT before", int'(c0), 1);
      cyc(1, 1, 1, 2'b10); chk("clr MATCH_M", int'(mm[0]), 0);
      cyc(0, 0, 1, 2'b00);
      chk("clr COUNT", int'(c0), 0);
      chk("clr PROG", int'(pg[0]), 0);
      chk("clr MATCH_R", int'(mr[0]), 0);

      cyc(0, 0, 0, 2'b00);
      cyc(0, 0, 0, 2'b00);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
